// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - note-table melody player feeding a square-wave tone generator
// LOAD latches one table entry, PLAY holds it for len ticks, GAP adds a silent articulation.
module melody_sequencer #(
   parameter int BW          = 16,
   parameter int AW          = 5,
   parameter int LW          = 3,
   parameter int LEN         = 32,
   parameter int TICK_CYCLES = 1200000,
   parameter int GAP_CYCLES  = 120000
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          stop_i,
   input  logic          loop_i,
   input  logic [BW-1:0] rom_divider_i,
   input  logic [LW-1:0] rom_len_i,
   output logic [AW-1:0] note_index_o,
   output logic [BW-1:0] divider_o,
   output logic          playing_o,
   output logic          note_strobe_o,
   output logic          done_o
);

   localparam int CMAX = (TICK_CYCLES > GAP_CYCLES) ? TICK_CYCLES : GAP_CYCLES;
   localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [CW-1:0] CYC_ONE   = CW'(1);
   localparam logic [AW-1:0] LAST_IDX  = AW'(LEN - 1);
   localparam logic [AW-1:0] IDX_ONE   = AW'(1);
   localparam logic [LW:0]   LEN_ONE   = (LW+1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] index_q, index_d;
   logic [BW-1:0] divider_q, divider_d;
   logic [LW:0]   len_q, len_d;
   logic [LW:0]   tick_q, tick_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic          playing_q, playing_d;
   logic          strobe_q, strobe_d;
   logic          done_q, done_d;
   logic          note_done;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         index_q   <= '0;
         divider_q <= '0;
         len_q     <= '0;
         tick_q    <= '0;
         cyc_q     <= '0;
         playing_q <= 1'b0;
         strobe_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         divider_q <= divider_d;
         len_q     <= len_d;
         tick_q    <= tick_d;
         cyc_q     <= cyc_d;
         playing_q <= playing_d;
         strobe_q  <= strobe_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      divider_d = '0;
      len_d     = len_q;
      tick_d    = tick_q;
      cyc_d     = cyc_q;
      strobe_d  = 1'b0;
      done_d    = 1'b0;
      note_done = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i && !stop_i) begin
               state_d = S_LOAD;
               index_d = '0;
            end
         end
         S_LOAD: begin
            state_d   = S_PLAY;
            divider_d = rom_divider_i;
            strobe_d  = 1'b1;
            len_d     = (rom_len_i == '0) ? LEN_ONE : {1'b0, rom_len_i};
            tick_d    = '0;
            cyc_d     = '0;
         end
         S_PLAY: begin
            divider_d = divider_q;
            if (cyc_q == TICK_LAST) begin
               cyc_d = '0;
               if (tick_q == len_q - LEN_ONE) begin
                  tick_d    = '0;
                  divider_d = '0;
                  if (GAP_CYCLES > 0) state_d = S_GAP;
                  else                note_done = 1'b1;
               end else begin
                  tick_d = tick_q + LEN_ONE;
               end
            end else begin
               cyc_d = cyc_q + CYC_ONE;
            end
         end
         S_GAP: begin
            if (cyc_q == GAP_LAST) begin
               cyc_d     = '0;
               note_done = 1'b1;
            end else begin
               cyc_d = cyc_q + CYC_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // loop_i only matters at the end of the final entry
      if (note_done) begin
         if (index_q != LAST_IDX) begin
            index_d = index_q + IDX_ONE;
            state_d = S_LOAD;
         end else if (loop_i) begin
            index_d = '0;
            state_d = S_LOAD;
         end else begin
            index_d = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
      end

      if (stop_i && state_q != S_IDLE) begin
         state_d   = S_IDLE;
         index_d   = '0;
         divider_d = '0;
         strobe_d  = 1'b0;
         done_d    = 1'b0;
         tick_d    = '0;
         cyc_d     = '0;
      end

      playing_d = (state_d != S_IDLE);
   end

   assign note_index_o  = index_q;
   assign divider_o     = divider_q;
   assign playing_o     = playing_q;
   assign note_strobe_o = strobe_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - randomized self-checking bench for melody_sequencer
// Expected traces are expanded from the note table as LOAD / len*TICK play / GAP segments.
module tb_melody_sequencer;

   localparam int TICK = 4;
   localparam int GAP  = 1;
   localparam int NLEN = 3;

   typedef struct packed {
      logic [15:0] div;
      logic [4:0]  idx;
      logic        play;
      logic        strobe;
      logic        done;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i, stop_i, loop_i;
   logic [15:0] rom_divider_i;
   logic [2:0]  rom_len_i;
   logic [4:0]  note_index_o;
   logic [15:0] divider_o;
   logic        playing_o, note_strobe_o, done_o;

   logic [15:0] tab_div [32];
   logic [2:0]  tab_len [32];
   obs_t        exp_q [$];
   obs_t        zero_obs;
   obs_t        got;
   int          checks = 0;
   int          errors = 0;

   melody_sequencer #(
      .BW(16), .AW(5), .LW(3), .LEN(NLEN), .TICK_CYCLES(TICK), .GAP_CYCLES(GAP)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i), .loop_i(loop_i),
      .rom_divider_i(rom_divider_i), .rom_len_i(rom_len_i),
      .note_index_o(note_index_o), .divider_o(divider_o), .playing_o(playing_o),
      .note_strobe_o(note_strobe_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   assign rom_divider_i = tab_div[note_index_o];
   assign rom_len_i     = tab_len[note_index_o];
   assign got = '{div: divider_o, idx: note_index_o, play: playing_o,
                  strobe: note_strobe_o, done: done_o};

   function automatic string fmt(input obs_t o);
      return $sformatf("div=%0d idx=%0d play=%0b strobe=%0b done=%0b",
                       o.div, o.idx, o.play, o.strobe, o.done);
   endfunction

   task automatic set_table(input logic [15:0] d0, input logic [2:0] l0,
                            input logic [15:0] d1, input logic [2:0] l1,
                            input logic [15:0] d2, input logic [2:0] l2);
      for (int i = 0; i < 32; i++) begin
         tab_div[i] = '0;
         tab_len[i] = '0;
      end
      tab_div[0] = d0; tab_len[0] = l0;
      tab_div[1] = d1; tab_len[1] = l1;
      tab_div[2] = d2; tab_len[2] = l2;
   endtask

   // Each entry: one silent LOAD cycle, len*TICK cycles sounding, GAP silent cycles.
   task automatic build_expect(input int passes);
      obs_t e;
      int   n;
      exp_q.delete();
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < NLEN; i++) begin
            n = ((tab_len[i] == 0) ? 1 : int'(tab_len[i])) * TICK;
            e = '{div: 16'd0, idx: 5'(i), play: 1'b1, strobe: 1'b0, done: 1'b0};
            exp_q.push_back(e);
            for (int c = 0; c < n; c++) begin
               e = '{div: tab_div[i], idx: 5'(i), play: 1'b1, strobe: (c == 0), done: 1'b0};
               exp_q.push_back(e);
            end
            for (int g = 0; g < GAP; g++) begin
               e = '{div: 16'd0, idx: 5'(i), play: 1'b1, strobe: 1'b0, done: 1'b0};
               exp_q.push_back(e);
            end
         end
      end
      exp_q.push_back('{div: 16'd0, idx: 5'd0, play: 1'b0, strobe: 1'b0, done: 1'b1});
      exp_q.push_back('{div: 16'd0, idx: 5'd0, play: 1'b0, strobe: 1'b0, done: 1'b0});
   endtask

   task automatic run_melody(input string name, input int passes, input bit hold_start,
                             input int stop_at);
      int pass_len;
      int sz;
      build_expect(passes);
      sz       = exp_q.size();
      pass_len = (sz - 2) / passes;
      @(negedge clk);
      loop_i  = (passes > 1);
      start_i = 1'b1;
      for (int k = 0; k < sz; k++) begin
         @(negedge clk);
         checks++;
         if (got !== exp_q[k]) begin
            errors++;
            $display("FAIL %s step %0d: got %s, want %s", name, k, fmt(got), fmt(exp_q[k]));
         end
         start_i = hold_start && (k + 1 < sz - 1);
         loop_i  = (passes > 1) && (k + 1 <= pass_len);
         if (k == stop_at) begin
            stop_i = 1'b1;
            @(negedge clk);
            stop_i  = 1'b0;
            start_i = 1'b0;
            for (int j = 0; j < 4; j++) begin
               checks++;
               if (got !== zero_obs) begin
                  errors++;
                  $display("FAIL %s after_stop %0d: got %s, want %s", name, j, fmt(got),
                           fmt(zero_obs));
               end
               @(negedge clk);
            end
            break;
         end
      end
      start_i = 1'b0;
      loop_i  = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (got !== zero_obs) begin
         errors++;
         $display("FAIL reset: got %s, want %s", fmt(got), fmt(zero_obs));
      end
      @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      checks++;
      if (got !== zero_obs) begin
         errors++;
         $display("FAIL reset_idle: got %s, want %s", fmt(got), fmt(zero_obs));
      end
   endtask

   task automatic test_reference_melody();
      set_table(16'd9097, 3'd1, 16'd0, 3'd2, 16'd7648, 3'd1);
      build_expect(1);
      checks++;
      if (exp_q.size() !== 24) begin
         errors++;
         $display("FAIL ref_length: got %0d, want %0d", exp_q.size(), 24);
      end
      run_melody("oneshot", 1, 1'b0, -1);
      run_melody("loop", 2, 1'b0, -1);
   endtask

   task automatic test_len_zero();
      set_table(16'd1234, 3'd0, 16'd55, 3'd1, 16'd0, 3'd0);
      run_melody("len_zero", 1, 1'b0, -1);
   endtask

   task automatic test_stop();
      set_table(16'd9097, 3'd1, 16'd0, 3'd2, 16'd7648, 3'd1);
      run_melody("stop_play", 1, 1'b0, 3);
      run_melody("stop_load", 1, 1'b0, 6);
      run_melody("stop_gap", 1, 1'b0, 5);
      run_melody("restart", 1, 1'b0, -1);
   endtask

   task automatic test_start_stop_idle();
      @(negedge clk);
      start_i = 1'b1;
      stop_i  = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         checks++;
         if (got !== zero_obs) begin
            errors++;
            $display("FAIL start_stop_idle %0d: got %s, want %s", j, fmt(got), fmt(zero_obs));
         end
      end
      start_i = 1'b0;
      stop_i  = 1'b0;
      set_table(16'd300, 3'd2, 16'd400, 3'd1, 16'd500, 3'd3);
      run_melody("start_held", 1, 1'b1, -1);
   endtask

   task automatic test_random();
      int passes;
      for (int r = 0; r < 8; r++) begin
         set_table(($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)),
                   3'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)),
                   3'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)),
                   3'($urandom_range(0, 7)));
         passes = int'($urandom_range(1, 2));
         if (r == 5) run_melody("random_stop", passes, 1'b0, int'($urandom_range(1, 20)));
         else        run_melody("random", passes, 1'b0, -1);
      end
   endtask

   task automatic test_async_reset();
      set_table(16'd9097, 3'd3, 16'd0, 3'd2, 16'd7648, 3'd1);
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (divider_o !== 16'd9097) begin
         errors++;
         $display("FAIL async_pre: got div=%0d, want div=%0d", divider_o, 16'd9097);
      end
      @(posedge clk);
      #2 rst_i = 1'b1;
      #1;
      checks++;
      if (got !== zero_obs) begin
         errors++;
         $display("FAIL async_reset: got %s, want %s", fmt(got), fmt(zero_obs));
      end
      @(negedge clk);
      rst_i = 1'b0;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         checks++;
         if (got !== zero_obs) begin
            errors++;
            $display("FAIL async_idle %0d: got %s, want %s", j, fmt(got), fmt(zero_obs));
         end
      end
      run_melody("after_reset", 1, 1'b0, -1);
   endtask

   initial begin
      zero_obs = '0;
      rst_i    = 1'b1;
      start_i  = 1'b0;
      stop_i   = 1'b0;
      loop_i   = 1'b0;
      set_table(16'd0, 3'd0, 16'd0, 3'd0, 16'd0, 3'd0);
      test_reset();
      test_reference_melody();
      test_len_zero();
      test_stop();
      test_start_stop_idle();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

endmodule
